// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: default line parameters,
// the receive state encoding and the 3-sample majority helper.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 87;
    localparam int PARITY_EN_DEFAULT    = 0;
    localparam int PARITY_ODD_DEFAULT   = 0;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } rx_state_t;

    function automatic logic majority3(input logic [2:0] samples);
        return (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line front end: 2-FF synchroniser plus a 3-point sample window around mid-bit.
// The vote is combinational on the MID+1 strobe cycle so the FSM can act on it at that edge.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int CW           = $clog2(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_serial,
    input  logic [CW-1:0] bit_count,
    output logic          rx_synced,
    output logic          vote,
    output logic          sample_strobe
);

    localparam int MID = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CW-1:0] SAMPLE_A = CW'(MID - 1);
    localparam logic [CW-1:0] SAMPLE_B = CW'(MID);
    localparam logic [CW-1:0] SAMPLE_C = CW'(MID + 1);

    logic [1:0] sync_ff;
    logic [1:0] history;

    // Preset to the idle-high level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff <= 2'b11;
        end else begin
            sync_ff <= {sync_ff[0], rx_serial};
        end
    end

    assign rx_synced = sync_ff[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            history <= 2'b11;
        end else if ((bit_count == SAMPLE_A) || (bit_count == SAMPLE_B)) begin
            history <= {history[0], rx_synced};
        end
    end

    // The third sample is the live synced value on the strobe cycle.
    assign sample_strobe = (bit_count == SAMPLE_C);
    assign vote          = majority3({history, rx_synced});

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receiver for 8N1/8E1/8O1 frames with majority-voted bits, parity,
// framing and break detection. Emits a one-cycle valid strobe per frame.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int PARITY_EN    = PARITY_EN_DEFAULT,
    parameter int PARITY_ODD   = PARITY_ODD_DEFAULT
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Parity_Err,
    output logic       o_Frame_Err,
    output logic       o_Break,
    output logic       o_Rx_Active
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);
    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    rx_state_t     state;
    logic [CW-1:0] bit_count;
    logic [2:0]    bit_index;
    logic [7:0]    shift_data;
    logic          parity_bit;
    logic          parity_err;

    logic rx_synced;
    logic vote;
    logic sample_strobe;
    logic bit_end;
    logic is_break;

    uart_bit_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CW           (CW)
    ) sampler (
        .clk           (i_Clock),
        .reset         (i_Reset),
        .rx_serial     (i_Rx_Serial),
        .bit_count     (bit_count),
        .rx_synced     (rx_synced),
        .vote          (vote),
        .sample_strobe (sample_strobe)
    );

    assign bit_end     = (bit_count == LAST_COUNT);
    assign is_break    = (shift_data == 8'h00) && !vote && (!PAR_EN || !parity_bit);
    assign o_Rx_Active = (state != IDLE);

    // The detect cycle counts as count 0 of the start bit, so START begins at count 1.
    // The frame ends at the stop-bit vote; the rest of the stop bit is spent in IDLE
    // so a back-to-back start edge is never missed.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state        <= IDLE;
            bit_count    <= '0;
            bit_index    <= '0;
            shift_data   <= '0;
            parity_bit   <= 1'b0;
            parity_err   <= 1'b0;
            o_Rx_DV      <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
        end else begin
            o_Rx_DV      <= 1'b0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
            bit_count    <= bit_end ? '0 : bit_count + 1'b1;

            case (state)
                IDLE: begin
                    bit_count <= '0;
                    bit_index <= '0;
                    if (!rx_synced) begin
                        state     <= START;
                        bit_count <= CW'(1);
                    end
                end
                START: begin
                    if (sample_strobe && vote) begin
                        state     <= IDLE;
                        bit_count <= '0;
                    end else if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (sample_strobe) begin
                        shift_data <= {vote, shift_data[7:1]};
                    end
                    if (bit_end) begin
                        bit_index <= bit_index + 3'd1;
                        if (bit_index == 3'd7) begin
                            state <= PAR_EN ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (sample_strobe) begin
                        parity_bit <= vote;
                        parity_err <= (((^shift_data) ^ vote) != PAR_ODD);
                    end
                    if (bit_end) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (sample_strobe) begin
                        o_Rx_DV      <= 1'b1;
                        o_Rx_Byte    <= shift_data;
                        o_Parity_Err <= PAR_EN & parity_err;
                        o_Frame_Err  <= !vote;
                        o_Break      <= is_break;
                        bit_count    <= '0;
                        state        <= is_break ? BREAK_WAIT : IDLE;
                    end
                end
                BREAK_WAIT: begin
                    bit_count <= '0;
                    if (rx_synced) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bit_count <= '0;
                end
            endcase
        end
    end

endmodule
